// File: rtl/md_sequencer.sv
// Multiply/divide sequencer: owns HI/LO, latches operands on start and commits
// the result on the last cycle of a fixed busy period.
module md_sequencer #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        start_o,
  output logic        busy,
  output logic [4:0]  busyCnt,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MULT = 2'd1,
    ST_DIV  = 2'd2
  } state_e;

  localparam logic [4:0] MULT_LAT = 5'(MULT_CYCLES);
  localparam logic [4:0] DIV_LAT  = 5'(DIV_CYCLES);

  // Two's-complement product of zero/sign-extended operands, low 64 bits.
  function automatic logic [63:0] mul64(input logic [31:0] a, input logic [31:0] b,
                                        input logic sgn);
    logic [63:0] ea;
    logic [63:0] eb;
    ea = {{32{sgn & a[31]}}, a};
    eb = {{32{sgn & b[31]}}, b};
    return ea * eb;
  endfunction

  function automatic logic [31:0] mag32(input logic [31:0] a, input logic sgn);
    return (sgn && a[31]) ? (32'd0 - a) : a;
  endfunction

  // Returns {remainder, quotient}; divisor zero is filtered out by the caller.
  function automatic logic [63:0] div64(input logic [31:0] a, input logic [31:0] b,
                                        input logic sgn);
    logic [31:0] ua;
    logic [31:0] ub;
    logic [31:0] uq;
    logic [31:0] ur;
    logic [31:0] q;
    logic [31:0] r;
    ua = mag32(a, sgn);
    ub = mag32(b, sgn);
    if (ub == 32'd0) begin
      uq = 32'd0;
      ur = 32'd0;
    end else begin
      uq = ua / ub;
      ur = ua % ub;
    end
    q = (sgn && (a[31] ^ b[31])) ? (32'd0 - uq) : uq;
    r = (sgn && a[31]) ? (32'd0 - ur) : ur;
    return {r, q};
  endfunction

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic        sgn_q, sgn_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        start_o_q, start_o_d;
  logic        busy_q, busy_d;
  logic [63:0] prod_s;
  logic [63:0] quot_s;

  // Result datapath, evaluated on the latched operands only.
  always_comb begin
    prod_s = mul64(a_q, b_q, sgn_q);
    quot_s = div64(a_q, b_q, sgn_q);
  end

  // Next-state, counter, operand latch and HI/LO commit logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    b_d       = b_q;
    sgn_d     = sgn_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    start_o_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          case (op)
            3'd0, 3'd1: begin
              a_d       = A;
              b_d       = B;
              sgn_d     = ~op[0];
              state_d   = ST_MULT;
              cnt_d     = MULT_LAT;
              start_o_d = 1'b1;
            end
            3'd2, 3'd3: begin
              a_d       = A;
              b_d       = B;
              sgn_d     = ~op[0];
              state_d   = ST_DIV;
              cnt_d     = DIV_LAT;
              start_o_d = 1'b1;
            end
            3'd4:    hi_d = A;
            3'd5:    lo_d = A;
            default: state_d = ST_IDLE;
          endcase
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MULT, ST_DIV: begin
        if (cnt_q <= 5'd1) begin
          cnt_d   = 5'd0;
          state_d = ST_IDLE;
          if (state_q == ST_MULT) begin
            {hi_d, lo_d} = prod_s;
          end else if (b_q != 32'd0) begin
            {hi_d, lo_d} = quot_s;
          end else begin
            hi_d = hi_q;
          end
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 5'd0;
      end
    endcase
    busy_d = (cnt_d != 5'd0);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 5'd0;
      a_q       <= 32'd0;
      b_q       <= 32'd0;
      sgn_q     <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      start_o_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      a_q       <= a_d;
      b_q       <= b_d;
      sgn_q     <= sgn_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      start_o_q <= start_o_d;
      busy_q    <= busy_d;
    end
  end

  assign start_o = start_o_q;
  assign busy    = busy_q;
  assign busyCnt = cnt_q;
  assign HI      = hi_q;
  assign LO      = lo_q;

endmodule

// File: tb/tb_md_sequencer.sv
// Directed-vector bench for md_sequencer: table of operations with hand-computed
// HI/LO results, plus start-while-busy and reset-mid-operation sequences.
module tb_md_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        start_o;
  logic        busy;
  logic [4:0]  busyCnt;
  logic [31:0] HI;
  logic [31:0] LO;

  int n_checks;
  int n_fail;

  md_sequencer #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
    .start_o(start_o), .busy(busy), .busyCnt(busyCnt), .HI(HI), .LO(LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          lat;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t vecs[13];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    logic [31:0] hi0;
    logic [31:0] lo0;
    hi0 = HI;
    lo0 = LO;
    start = 1'b1; op = v.op; A = v.a; B = v.b;
    tick();
    start = 1'b0; A = 32'h0; B = 32'h0; op = 3'd7;
    check($sformatf("v%0d start_o", idx), {31'd0, start_o}, {31'd0, v.lat != 0});
    check($sformatf("v%0d cnt_load", idx), {27'd0, busyCnt}, 32'(v.lat));
    for (int k = v.lat - 1; k >= 0; k--) begin
      check($sformatf("v%0d hi_hold", idx), HI, hi0);
      check($sformatf("v%0d lo_hold", idx), LO, lo0);
      tick();
      check($sformatf("v%0d cnt%0d", idx, k), {27'd0, busyCnt}, 32'(k));
      check($sformatf("v%0d busy%0d", idx, k), {31'd0, busy}, {31'd0, k != 0});
      check($sformatf("v%0d start_o_low", idx), {31'd0, start_o}, 32'd0);
    end
    check($sformatf("v%0d HI", idx), HI, v.exp_hi);
    check($sformatf("v%0d LO", idx), LO, v.exp_lo);
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    start = 1'b0; op = 3'd7; A = 32'h0; B = 32'h0;
    reset = 1'b1;

    vecs[0]  = '{3'd0, 32'hFFFFFFFD, 32'h00000005, 5,  32'hFFFFFFFF, 32'hFFFFFFF1};
    vecs[1]  = '{3'd1, 32'hFFFFFFFF, 32'h00000002, 5,  32'h00000001, 32'hFFFFFFFE};
    vecs[2]  = '{3'd2, 32'hFFFFFFF9, 32'h00000002, 10, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3]  = '{3'd3, 32'h00000007, 32'h00000002, 10, 32'h00000001, 32'h00000003};
    vecs[4]  = '{3'd4, 32'h00001234, 32'h00000000, 0,  32'h00001234, 32'h00000003};
    vecs[5]  = '{3'd2, 32'h00000005, 32'h00000000, 10, 32'h00001234, 32'h00000003};
    vecs[6]  = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000};
    vecs[7]  = '{3'd5, 32'hCAFEF00D, 32'h00000000, 0,  32'h00000000, 32'hCAFEF00D};
    vecs[8]  = '{3'd2, 32'h00000007, 32'hFFFFFFFE, 10, 32'h00000001, 32'hFFFFFFFD};
    vecs[9]  = '{3'd0, 32'h80000000, 32'h80000000, 5,  32'h40000000, 32'h00000000};
    vecs[10] = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5,  32'hFFFFFFFE, 32'h00000001};
    vecs[11] = '{3'd3, 32'hFFFFFFFF, 32'h0000000A, 10, 32'h00000005, 32'h19999999};
    vecs[12] = '{3'd6, 32'h11111111, 32'h22222222, 0,  32'h00000005, 32'h19999999};

    tick();
    tick();
    reset = 1'b0;
    check("rst HI", HI, 32'h0);
    check("rst LO", LO, 32'h0);
    check("rst busyCnt", {27'd0, busyCnt}, 32'h0);
    check("rst busy", {31'd0, busy}, 32'h0);
    check("rst start_o", {31'd0, start_o}, 32'h0);

    // Vectors run back-to-back: each start lands in the cycle right after commit.
    for (int i = 0; i < 13; i++) begin
      run_vec(i, vecs[i]);
    end

    // Start while busy: mult 6*7, div 100/7 pulsed at busyCnt=3 must be ignored.
    start = 1'b1; op = 3'd0; A = 32'd6; B = 32'd7;
    tick();
    start = 1'b0;
    check("sb cnt5", {27'd0, busyCnt}, 32'd5);
    tick();
    tick();
    check("sb cnt3", {27'd0, busyCnt}, 32'd3);
    start = 1'b1; op = 3'd2; A = 32'd100; B = 32'd7;
    tick();
    start = 1'b0; A = 32'h0; B = 32'h0;
    check("sb cnt2", {27'd0, busyCnt}, 32'd2);
    check("sb start_o", {31'd0, start_o}, 32'd0);
    tick();
    check("sb cnt1", {27'd0, busyCnt}, 32'd1);
    tick();
    check("sb cnt0", {27'd0, busyCnt}, 32'd0);
    check("sb HI", HI, 32'h0);
    check("sb LO", LO, 32'd42);
    tick();
    check("sb no reload", {27'd0, busyCnt}, 32'd0);
    check("sb LO stable", LO, 32'd42);

    // Reset at busyCnt=4 of a div: nothing commits afterwards.
    start = 1'b1; op = 3'd3; A = 32'd100; B = 32'd7;
    tick();
    start = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    check("rm cnt4", {27'd0, busyCnt}, 32'd4);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rm busyCnt", {27'd0, busyCnt}, 32'd0);
    check("rm busy", {31'd0, busy}, 32'd0);
    check("rm HI", HI, 32'h0);
    check("rm LO", LO, 32'h0);
    for (int k = 0; k < 12; k++) tick();
    check("rm late HI", HI, 32'h0);
    check("rm late LO", LO, 32'h0);
    check("rm late cnt", {27'd0, busyCnt}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
